// File: rtl/video_timing_generator.sv
// Run-time programmable raster timing generator. A shadow timing bank is committed to the
// active bank at frame end; decoded sync/blank/colour/interrupt outputs lag the counters by one tick.
module video_timing_generator #(
    parameter int CW        = 9,
    parameter int CDW       = 3,
    parameter int RST_END_H = 447,
    parameter int RST_END_V = 311
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clken,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [CW-1:0]  cfg_wdata,
    input  logic           cfg_commit,
    output logic           cfg_pending,
    input  logic           vint_enable,
    input  logic           rint_enable,
    input  logic [CW-1:0]  raster_line,
    input  logic [CDW-1:0] ri,
    input  logic [CDW-1:0] gi,
    input  logic [CDW-1:0] bi,
    output logic [CDW-1:0] ro,
    output logic [CDW-1:0] go,
    output logic [CDW-1:0] bo,
    output logic [CW-1:0]  hcnt,
    output logic [CW-1:0]  vcnt,
    output logic           hsync,
    output logic           vsync,
    output logic           csync,
    output logic           hblank,
    output logic           vblank,
    output logic           frame_start,
    output logic           int_n,
    output logic           raster_int_in_progress
);

    localparam int NREG      = 15;
    localparam int IDX_END_H = 0;
    localparam int IDX_END_V = 1;
    localparam int IDX_HB_B  = 2;
    localparam int IDX_HB_E  = 3;
    localparam int IDX_HS_B  = 4;
    localparam int IDX_HS_E  = 5;
    localparam int IDX_VB_B  = 6;
    localparam int IDX_VB_E  = 7;
    localparam int IDX_VS_B  = 8;
    localparam int IDX_VS_E  = 9;
    localparam int IDX_VCINT = 10;
    localparam int IDX_VI_B  = 11;
    localparam int IDX_VI_E  = 12;
    localparam int IDX_RI_B  = 13;
    localparam int IDX_RI_E  = 14;

    typedef logic [CW-1:0] word_t;

    function automatic word_t rst_val(input int idx);
        case (idx)
            IDX_END_H: return word_t'(RST_END_H);
            IDX_END_V: return word_t'(RST_END_V);
            IDX_HB_B:  return word_t'(320);
            IDX_HB_E:  return word_t'(415);
            IDX_HS_B:  return word_t'(344);
            IDX_HS_E:  return word_t'(375);
            IDX_VB_B:  return word_t'(248);
            IDX_VB_E:  return word_t'(255);
            IDX_VS_B:  return word_t'(248);
            IDX_VS_E:  return word_t'(251);
            IDX_VCINT: return word_t'(248);
            IDX_VI_B:  return word_t'(4);
            IDX_VI_E:  return word_t'(67);
            IDX_RI_B:  return word_t'(256);
            default:   return word_t'(319);
        endcase
    endfunction

    // Inclusive window; begin > end naturally yields an empty window, never a wrapped one.
    function automatic logic in_win(input word_t x, input word_t b, input word_t e);
        return (x >= b) && (x <= e);
    endfunction

    word_t shadow_q [NREG];
    word_t active_q [NREG];

    logic frame_end;
    logic apply_commit;
    logic line_hit;
    logic hb_d, vb_d, hs_d, vs_d, fs_d, vint_d, rint_d;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        frame_end    = (hcnt == active_q[IDX_END_H]) && (vcnt == active_q[IDX_END_V]);
        apply_commit = clken && frame_end && (cfg_pending || cfg_commit);
        if (raster_line == '0)
            line_hit = (vcnt == active_q[IDX_END_V]);
        else
            line_hit = (vcnt == raster_line - word_t'(1));
        hb_d   = in_win(hcnt, active_q[IDX_HB_B], active_q[IDX_HB_E]);
        vb_d   = in_win(vcnt, active_q[IDX_VB_B], active_q[IDX_VB_E]);
        hs_d   = in_win(hcnt, active_q[IDX_HS_B], active_q[IDX_HS_E]);
        vs_d   = in_win(vcnt, active_q[IDX_VS_B], active_q[IDX_VS_E]);
        fs_d   = (hcnt == '0) && (vcnt == '0);
        vint_d = vint_enable && (vcnt == active_q[IDX_VCINT])
                 && in_win(hcnt, active_q[IDX_VI_B], active_q[IDX_VI_E]);
        rint_d = rint_enable && line_hit && in_win(hcnt, active_q[IDX_RI_B], active_q[IDX_RI_E]);
    end

    // NOTE: the timing banks are control state, not storage, so both are reset to defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= rst_val(i);
                active_q[i] <= rst_val(i);
            end
            cfg_pending <= 1'b0;
        end else begin
            // Active bank takes the shadow as it stood before this cycle's write.
            for (int i = 0; i < NREG; i++) begin
                if (apply_commit)
                    active_q[i] <= shadow_q[i];
                if (cfg_we && cfg_addr == 4'(i))
                    shadow_q[i] <= cfg_wdata;
            end
            if (apply_commit)
                cfg_pending <= 1'b0;
            else if (cfg_commit)
                cfg_pending <= 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt                   <= '0;
            vcnt                   <= '0;
            hsync                  <= 1'b1;
            vsync                  <= 1'b1;
            csync                  <= 1'b1;
            hblank                 <= 1'b0;
            vblank                 <= 1'b0;
            frame_start            <= 1'b0;
            int_n                  <= 1'b1;
            raster_int_in_progress <= 1'b0;
            ro                     <= '0;
            go                     <= '0;
            bo                     <= '0;
        end else if (clken) begin
            if (hcnt == active_q[IDX_END_H]) begin
                hcnt <= '0;
                vcnt <= (vcnt == active_q[IDX_END_V]) ? '0 : vcnt + word_t'(1);
            end else begin
                hcnt <= hcnt + word_t'(1);
            end
            hsync                  <= ~hs_d;
            vsync                  <= ~vs_d;
            csync                  <= ~hs_d & ~vs_d;
            hblank                 <= hb_d;
            vblank                 <= vb_d;
            frame_start            <= fs_d;
            int_n                  <= ~(vint_d | rint_d);
            raster_int_in_progress <= rint_d;
            ro                     <= (hb_d || vb_d) ? '0 : ri;
            go                     <= (hb_d || vb_d) ? '0 : gi;
            bo                     <= (hb_d || vb_d) ? '0 : bi;
        end
    end

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench for video_timing_generator: a cycle model pushes expected decoded outputs
// per clken tick; they are popped and compared one tick later against the registered outputs.
module tb_video_timing_generator;

    localparam int CW      = 9;
    localparam int CDW     = 3;
    localparam int P_END_H = 447;
    localparam int P_END_V = 15;

    typedef logic [8+3*CDW-1:0] dec_t;

    logic           clk;
    logic           rst_n;
    logic           clken;
    logic           cfg_we;
    logic [3:0]     cfg_addr;
    logic [CW-1:0]  cfg_wdata;
    logic           cfg_commit;
    logic           cfg_pending;
    logic           vint_enable;
    logic           rint_enable;
    logic [CW-1:0]  raster_line;
    logic [CDW-1:0] ri, gi, bi, ro, go, bo;
    logic [CW-1:0]  hcnt, vcnt;
    logic           hsync, vsync, csync, hblank, vblank, frame_start, int_n, raster_int_in_progress;
    dec_t           dut_dec;

    video_timing_generator #(
        .CW(CW), .CDW(CDW), .RST_END_H(P_END_H), .RST_END_V(P_END_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clken(clken),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
        .vint_enable(vint_enable), .rint_enable(rint_enable), .raster_line(raster_line),
        .ri(ri), .gi(gi), .bi(bi), .ro(ro), .go(go), .bo(bo),
        .hcnt(hcnt), .vcnt(vcnt),
        .hsync(hsync), .vsync(vsync), .csync(csync),
        .hblank(hblank), .vblank(vblank), .frame_start(frame_start),
        .int_n(int_n), .raster_int_in_progress(raster_int_in_progress)
    );

    assign dut_dec = {hsync, vsync, csync, hblank, vblank, frame_start, int_n,
                      raster_int_in_progress, ro, go, bo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int   rst_tab [15] = '{P_END_H, P_END_V, 320, 415, 344, 375, 248, 255, 248, 251, 248, 4, 67, 256, 319};
    int   m_sh [15];
    int   m_act [15];
    int   m_h, m_v;
    bit   m_pend;
    dec_t exp_q [$];
    dec_t last_exp;

    // Stimulus control and per-run statistics
    int duty  = 1;
    int phase = 0;
    int n_len, n_cyc, n_int_low, n_hb_high, n_rip;

    function automatic bit win(input int x, input int b, input int e);
        return (x >= b) && (x <= e);
    endfunction

    task automatic model_reset();
        m_h = 0;
        m_v = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 15; i++) begin
            m_sh[i]  = rst_tab[i];
            m_act[i] = rst_tab[i];
        end
        exp_q.delete();
        last_exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {(3*CDW){1'b0}}};
    endtask

    task automatic model_step();
        bit hb, vb, hs, vs, fs, vi, rn, hit, fe, ap;
        logic [CDW-1:0] r, g, b;
        if (clken) begin
            hb  = win(m_h, m_act[2], m_act[3]);
            vb  = win(m_v, m_act[6], m_act[7]);
            hs  = win(m_h, m_act[4], m_act[5]);
            vs  = win(m_v, m_act[8], m_act[9]);
            fs  = (m_h == 0) && (m_v == 0);
            vi  = vint_enable && (m_v == m_act[10]) && win(m_h, m_act[11], m_act[12]);
            hit = (raster_line == '0) ? (m_v == m_act[1]) : (m_v + 1 == int'(raster_line));
            rn  = rint_enable && hit && win(m_h, m_act[13], m_act[14]);
            r   = (hb || vb) ? '0 : ri;
            g   = (hb || vb) ? '0 : gi;
            b   = (hb || vb) ? '0 : bi;
            exp_q.push_back({!hs, !vs, !hs && !vs, hb, vb, fs, !(vi || rn), rn, r, g, b});
        end
        fe = clken && (m_h == m_act[0]) && (m_v == m_act[1]);
        ap = fe && (m_pend || cfg_commit);
        if (clken) begin
            if (m_h == m_act[0]) begin
                m_h = 0;
                m_v = (m_v == m_act[1]) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        if (ap)
            for (int i = 0; i < 15; i++) m_act[i] = m_sh[i];
        if (ap)
            m_pend = 1'b0;
        else if (cfg_commit)
            m_pend = 1'b1;
        if (cfg_we && cfg_addr != 4'd15)
            m_sh[cfg_addr] = int'(cfg_wdata);
    endtask

    task automatic compare_now(input string tag);
        check({tag, "_dec"}, 32'(dut_dec), 32'(last_exp));
        check({tag, "_cnt"}, {13'd0, cfg_pending, hcnt, vcnt}, {13'd0, m_pend, CW'(m_h), CW'(m_v)});
    endtask

    task automatic tick();
        logic [31:0] rnd;
        rnd = $urandom;
        ri  = rnd[CDW-1:0];
        gi  = rnd[CDW+:CDW];
        bi  = rnd[2*CDW+:CDW];
        clken = (duty <= 1) ? 1'b1 : ((phase % duty) == 0);
        phase++;
        model_step();
        @(posedge clk);
        #1;
        n_cyc++;
        if (clken) begin
            if (exp_q.size() > 0)
                last_exp = exp_q.pop_front();
            n_len++;
            if (!int_n) n_int_low++;
            if (hblank) n_hb_high++;
            if (raster_int_in_progress) n_rip++;
        end
        compare_now("tick");
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_wdata = CW'(data);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic clear_stats();
        n_len = 0; n_cyc = 0; n_int_low = 0; n_hb_high = 0; n_rip = 0;
    endtask

    // Ticks until the counters have just wrapped to (0,0); statistics cover exactly that span.
    task automatic run_to_frame_start(input string tag);
        bit ok;
        ok = 1'b0;
        clear_stats();
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (clken && m_h == 0 && m_v == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_wait"}, 32'(ok), 32'd1);
    endtask

    // Stops with the next tick being the frame-end tick (clken held high).
    task automatic run_to_frame_end(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (m_h == m_act[0] && m_v == m_act[1]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_wait"}, 32'(ok), 32'd1);
    endtask

    int small_cfg [15] = '{47, 19, 40, 45, 41, 44, 16, 19, 17, 18, 17, 4, 10, 20, 30};
    int hs_low;

    initial begin
        rst_n = 1'b0; clken = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_commit = 1'b0; vint_enable = 1'b1; rint_enable = 1'b0; raster_line = '0;
        ri = '0; gi = '0; bi = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_now("reset");
        rst_n = 1'b1;

        // Default timing: 32 hsync-low ticks per 448-tick line
        hs_low = 0;
        for (int i = 0; i < 448; i++) begin
            tick();
            if (!hsync) hs_low++;
        end
        check("hsync_width", 32'(hs_low), 32'd32);

        // Program a compact timing set and commit mid-frame
        for (int i = 0; i < 15; i++) wr(i, small_cfg[i]);
        commit();
        check("pending_set", 32'(cfg_pending), 32'd1);
        run_to_frame_start("first_switch");
        check("pending_clr", 32'(cfg_pending), 32'd0);
        run_to_frame_start("small_frame");
        check("small_len", 32'(n_len), 32'd960);
        check("vint_ticks", 32'(n_int_low), 32'd7);

        // Commit and shadow write in the frame-end tick: old shadow value applies
        run_to_frame_end("same_cycle");
        cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = CW'(59);
        tick();
        cfg_commit = 1'b0; cfg_we = 1'b0;
        check("same_cycle_pend", 32'(cfg_pending), 32'd0);
        run_to_frame_start("old_value");
        check("old_value_len", 32'(n_len), 32'd960);
        commit();
        run_to_frame_start("apply_500");
        run_to_frame_start("new_value");
        check("new_value_len", 32'(n_len), 32'd1200);

        // Raster interrupt targets
        vint_enable = 1'b0;
        rint_enable = 1'b1;
        raster_line = CW'(0);
        run_to_frame_start("rl0");
        check("rl0_ticks", 32'(n_rip), 32'd11);
        raster_line = CW'(1);
        run_to_frame_start("rl1");
        check("rl1_ticks", 32'(n_int_low), 32'd11);
        raster_line = CW'(21);
        run_to_frame_start("rl_out");
        check("rl_out_ticks", 32'(n_int_low), 32'd0);
        rint_enable = 1'b0;

        // Empty hblank window, then quarter-rate clken
        wr(2, 40);
        wr(3, 30);
        commit();
        run_to_frame_start("hb_apply");
        run_to_frame_start("hb_empty");
        check("hb_empty_ticks", 32'(n_hb_high), 32'd0);
        duty = 4;
        phase = 0;
        run_to_frame_start("duty");
        check("duty_len", 32'(n_len), 32'd1200);
        check("duty_cycles", 32'(n_cyc), 32'd4797);
        wr(1, 23);
        wr(15, 5);
        commit();
        check("pending_lowclk", 32'(cfg_pending), 32'd1);
        run_to_frame_start("duty_apply");
        duty = 1;
        run_to_frame_start("tall_frame");
        check("tall_len", 32'(n_len), 32'd1440);

        // Asynchronous reset mid-line with a commit pending
        commit();
        for (int i = 0; i < 100 && m_h != 30; i++) tick();
        check("pre_reset_h", 32'(hcnt), 32'd30);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_now("async_reset");
        repeat (2) @(posedge clk);
        #1;
        compare_now("reset_hold");
        rst_n = 1'b1;
        hs_low = 0;
        for (int i = 0; i < 896; i++) begin
            tick();
            if (!hsync) hs_low++;
        end
        check("post_reset_hsync", 32'(hs_low), 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
